// File: rtl/tdm_mux4_if.sv
// tdm_mux4_if: channel-select bus between four input streams and one tagged output word.
// Latency: none (wires only).
// Backpressure: carries in_ready per channel and out_ready from downstream.
// Ports: in_data/in_valid/in_ready per-channel side; out_data/out_sel/out_en/out_ready merged side.
//   slave  : the merging block (takes channel words, drives the output stage)
//   master : the environment (drives channel words and out_ready)
interface tdm_mux4_if #(
  parameter int WIDTH = 8
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_en;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_en
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_en
  );
endinterface

// File: rtl/tdm_mux4.sv
// tdm_mux4: round-robin merge of four WIDTH-bit channels into one registered word tagged with its channel.
// Latency: one cycle from input handshake to out_en/out_data/out_sel.
// Backpressure: output stage holds while out_en && !out_ready; in_ready is all-zero in that case.
// Ports: clk, rst_n (async active-low);
//        bus (slave): in_data/in_valid/in_ready channel side, out_data/out_sel/out_en/out_ready output side.
module tdm_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  tdm_mux4_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_q;
  logic [1:0]       last_q;
  logic [1:0]       grant;
  logic [1:0]       cand;
  logic             found;
  logic             any_vld;
  logic             load_ok;
  logic             load;

  assign any_vld = |bus.in_valid;
  assign load_ok = (state == EMPTY) || bus.out_ready;
  assign load    = load_ok && any_vld;

  // Round-robin search starting one past the last grant; k=4 wraps back to last_q,
  // so the previous winner only wins again when nobody else is asking.
  always_comb begin
    grant = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Registers are held in reset while rst_n is low, so nothing may be taken then;
  // gating with rst_n keeps an upstream word from being lost during reset.
  always_comb begin
    bus.in_ready = 4'b0000;
    if (rst_n && load) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  // Output-stage occupancy FSM: a load refills it, an empty-input consume drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load_ok) begin
      state_nxt = any_vld ? FULL : EMPTY;
    end
  end

  // Word, tag and round-robin pointer only move on a load; last_q resets to 3 so
  // the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= 2'b00;
      last_q <= 2'b11;
    end else if (load) begin
      data_q <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
      sel_q  <= grant;
      last_q <= grant;
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_sel  = sel_q;
  assign bus.out_en   = (state == FULL);

endmodule

// File: tb/tb_tdm_mux4.sv
module tb_tdm_mux4;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] dat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  tdm_mux4_if #(.WIDTH(8)) bus ();

  tdm_mux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] d);
    bus.in_data[c*8 +: 8] = d;
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d);
    exp_t e;
    e.sel = s;
    e.dat = d;
    sb.push_back(e);
  endtask

  task automatic chk_rdy_neg(input string name, input logic [3:0] exp);
    @(negedge clk);
    check(name, 32'(bus.in_ready), 32'(exp));
  endtask

  // Monitor: every word the output stage hands over must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_en && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got sel=%0d data=%0h, expected no word", bus.out_sel, bus.out_data);
        end else begin
          e = sb.pop_front();
          check("word_sel", 32'(bus.out_sel), 32'(e.sel));
          check("word_data", 32'(bus.out_data), 32'(e.dat));
        end
      end
    end
  end

  logic [1:0] rr_seq [8];

  initial begin
    checks = 0;
    errors = 0;
    rr_seq = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    // Reset with arbitrary inputs
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    #3;
    check("rst_out_en", 32'(bus.out_en), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_sel", 32'(bus.out_sel), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 4'b0000;
    #2;
    rst_n = 1'b1;

    // First word after reset: ch0 = 11
    step();
    set_ch(0, 8'h11);
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    push(2'd0, 8'h11);
    chk_rdy_neg("first_in_ready", 4'b0001);
    step();
    bus.in_valid = 4'b0000;
    check("first_out_en", 32'(bus.out_en), 1);

    // Single channel 2 (last = 0 now)
    step();
    set_ch(2, 8'hA5);
    bus.in_valid = 4'b0100;
    push(2'd2, 8'hA5);
    chk_rdy_neg("single_in_ready", 4'b0100);
    step();
    bus.in_valid = 4'b0000;
    check("single_out_sel", 32'(bus.out_sel), 2);
    step();
    check("idle_out_en", 32'(bus.out_en), 0);

    // Round-robin with all valid; last = 2 so the rotation starts at 3
    for (int c = 0; c < 4; c++) set_ch(c, 8'hC0 + 8'(c));
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push(rr_seq[i], 8'hC0 + 8'(rr_seq[i]));
      chk_rdy_neg("rr_in_ready", 4'b0001 << rr_seq[i]);
      step();
    end

    // Skip/wrap: take ch0 to set last=0, then 1001 -> 3, 0, 3
    set_ch(0, 8'h50);
    bus.in_valid = 4'b0001;
    push(2'd0, 8'h50);
    chk_rdy_neg("wrap_pre_in_ready", 4'b0001);
    step();
    set_ch(0, 8'h90);
    set_ch(3, 8'h93);
    bus.in_valid = 4'b1001;
    push(2'd3, 8'h93);
    chk_rdy_neg("wrap_in_ready_a", 4'b1000);
    step();
    push(2'd0, 8'h90);
    chk_rdy_neg("wrap_in_ready_b", 4'b0001);
    step();
    push(2'd3, 8'h93);
    chk_rdy_neg("wrap_in_ready_c", 4'b1000);
    step();

    // Backpressure: load ch1=3C, then stall 3 cycles with all valid
    set_ch(1, 8'h3C);
    bus.in_valid = 4'b0010;
    push(2'd1, 8'h3C);
    step();
    for (int c = 0; c < 4; c++) set_ch(c, 8'h40 + 8'(c));
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_out_en", 32'(bus.out_en), 1);
      check("bp_out_sel", 32'(bus.out_sel), 1);
      check("bp_out_data", 32'(bus.out_data), 32'h3C);
      step();
    end
    bus.out_ready = 1'b1;
    push(2'd2, 8'h42);
    chk_rdy_neg("bp_release_in_ready", 4'b0100);
    step();
    bus.in_valid = 4'b0000;
    check("bp_no_bubble_en", 32'(bus.out_en), 1);
    check("bp_no_bubble_sel", 32'(bus.out_sel), 2);
    step();
    check("bp_drain_en", 32'(bus.out_en), 0);

    // Reset mid-stream: a stalled word is discarded
    set_ch(0, 8'h77);
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 4'b0000;
    check("mid_loaded_en", 32'(bus.out_en), 1);
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 8'hC0 + 8'(c));
    bus.in_valid = 4'b1111;
    #1;
    check("mid_rst_out_en", 32'(bus.out_en), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    push(2'd0, 8'hC0);
    step();
    bus.in_valid = 4'b0000;
    check("mid_first_sel", 32'(bus.out_sel), 0);
    step();
    step();
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
